data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Responder end of the load/store buffer's word-wide memory interface (mem_req/mem_we/mem_addr/mem_wdata/mem_mask -> mem_ready/mem_rdata/mem_rvalid). It serialises each accepted word request onto a byte-wide synchronous RAM port with 1-cycle read latency. Loads return the full aligned word; lane extraction and sign extension stay in the requester. Stores write only the masked byte lanes.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width; mem_addr bits above this are ignored.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush; aborts reads, never aborts writes
mem_req  in  1  request valid
mem_we  in  1  1 = store, 0 = load
mem_addr  in  32  byte address; controller uses word base {mem_addr[ADDR_WIDTH-1:2], 2'b00}
mem_wdata  in  32  store data, already lane-aligned (byte i in bits 8i+7:8i)
mem_mask  in  4  store byte-lane enables
mem_ready  out  1  registered; high only in IDLE
mem_rdata  out  32  load result word; byte i = RAM[base+i]
mem_rvalid  out  1  one-cycle pulse, qualifies mem_rdata
ram_addr  out  ADDR_WIDTH  RAM byte address
ram_dout  out  8  RAM write data
ram_wr  out  1  RAM write enable
ram_din  in  8  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- Reset values: mem_ready=1, mem_rvalid=0, mem_rdata=0, ram_wr=0, ram_addr=0, ram_dout=0; state=IDLE.
- rst dominates everything. A reset mid-write abandons the remaining bytes, and ram_wr=0 on the next cycle.
- Handshake: a request is accepted on a rising edge with mem_req=1 and mem_ready=1 and flush=0 (the accept edge, E0). mem_ready drops after E0.
- On acceptance, latch we, base, wdata and mask.
- A request that coincides with flush is dropped; the controller stays in IDLE.
- States: IDLE, READ, WRITE.

READ:
- Drives ram_addr = base+0..base+3 in the cycles after E0..E3, with ram_wr=0.
- Captures ram_din into byte k at edge E(k+2).
- At E5, assembles {ram_din, b2, b1, b0} into mem_rdata, sets mem_rvalid=1 and mem_ready=1, and returns to IDLE.
- mem_rvalid is high for exactly the cycle after E5, then clears. mem_rdata holds its value until the next load completes.
- flush at any edge during READ: go to IDLE, mem_ready=1, no mem_rvalid ever for that request, and mem_rdata is unchanged.

WRITE:
- Services set mask bits lowest lane first, one per cycle, skipping clear lanes.
- For lane i: ram_addr=base+i, ram_dout=wdata[8i+7:8i], ram_wr=1.
- Cycle count equals popcount(mask). Non-contiguous masks are legal.
- After the last write cycle, ram_wr=0 and mem_ready=1 (IDLE) at the following edge.
- mask=0000: no RAM write, and mem_ready returns after E1.
- flush during WRITE is ignored; the write completes.
- No mem_rvalid for stores; the requester treats acceptance as completion.
- Idle outputs: ram_wr=0, and ram_addr holds its last value.
- Address wrap: base+i computed modulo 2^ADDR_WIDTH. Base is word aligned, so no carry past bit 1 occurs.
- No back-to-back acceptance: at least one IDLE cycle (mem_ready=1) precedes every accept.

Decomposition:
- Shared package (params.v): state encodings S_IDLE/S_READ/S_WRITE, byte-lane count 4, MEM_ADDR_WIDTH default.
- Optional sub-module mask_next_lane: combinational priority encoder. Given a remaining 4-bit mask it outputs the next lane index and a "none left" flag. WRITE clears the serviced bit each cycle.
- Byte counter and READ capture logic stay inline.

Test Plan:
1. LW: preload RAM[0x100..0x103]=0x11,0x22,0x33,0x44; mem_req, mem_we=0, addr=0x102 -> ram_addr 0x100..0x103; after E5 mem_rvalid pulses 1 cycle with mem_rdata=0x44332211; mem_ready=1 same cycle.
2. SW then readback: addr=0x200, mask=1111, wdata=0xDEADBEEF -> 4 ram_wr cycles writing EF,BE,AD,DE at 0x200..0x203; mem_ready low for 4 cycles; a subsequent LW returns 0xDEADBEEF.
3. SB lane 2: addr=0x302, mask=0100, wdata=0x00AB0000 -> exactly one ram_wr at 0x302 with data 0xAB; mem_ready back after E1; RAM[0x300,0x301,0x303] unchanged.
4. Flush mid-read: LW accepted, flush asserted at E2 -> no mem_rvalid ever; mem_ready=1 next cycle; mem_rdata retains the prior value; a following LW works normally.
5. Flush mid-write and on accept: flush at E1 of a SW -> all 4 bytes still written. Separately, mem_req together with flush in IDLE -> no acceptance, and no RAM activity.
6. Reset mid-write plus mask corner cases: rst at E2 of a SW -> only bytes 0,1 written, and all outputs at reset values. mask=0000 and mask=1001 -> 0 and 2 write cycles (lanes 0,3) respectively.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the word-to-byte data memory controller:
// FSM states, lane count, default RAM address width and lane helpers.
package data_mem_ctrl_pkg;

    localparam int unsigned LANES          = 4;
    localparam int unsigned MEM_ADDR_WIDTH = 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    typedef logic [1:0] lane_t;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input lane_t lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-wide request/response bus between the load/store buffer (master)
// and the data memory controller (slave).
interface data_mem_ctrl_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output req, we, addr, wdata, mask,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata, mask,
        output ready, rdata, rvalid
    );

endinterface

// File: rtl/data_mem_ctrl_mask_next_lane.sv
// Priority encoder over the remaining store byte-lane mask: lowest set lane
// first, with a flag when no lanes remain.
module data_mem_ctrl_mask_next_lane
    import data_mem_ctrl_pkg::*;
(
    input  logic [3:0] mask,
    output lane_t      lane,
    output logic       none
);

    always_comb begin
        none = (mask == '0);
        lane = '0;
        if (mask[0]) begin
            lane = 2'd0;
        end else if (mask[1]) begin
            lane = 2'd1;
        end else if (mask[2]) begin
            lane = 2'd2;
        end else if (mask[3]) begin
            lane = 2'd3;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Responder for word-wide loads/stores, serialised onto a byte-wide
// synchronous RAM port with one cycle of read latency.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    data_mem_ctrl_if.slave        mem,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    input  logic [7:0]            ram_din
);

    localparam int unsigned WW = ADDR_WIDTH - 2;

    state_t                state_q, state_n;
    logic                  ready_q, ready_n;
    logic                  rvalid_q, rvalid_n;
    logic [31:0]           rdata_q, rdata_n;
    logic [ADDR_WIDTH-1:0] ram_addr_n;
    logic [7:0]            ram_dout_n;
    logic                  ram_wr_n;
    logic [WW-1:0]         base_q, base_n;
    logic [31:0]           wdata_q, wdata_n;
    logic [3:0]            rem_q, rem_n;
    logic [2:0]            cnt_q, cnt_n;
    logic [23:0]           rbytes_q, rbytes_n;

    logic                  accept;
    logic                  issue_store;
    logic [3:0]            sel_mask;
    logic [WW-1:0]         sel_base;
    logic [31:0]           sel_wdata;
    lane_t                 lane;
    logic                  none_left;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{mem.addr[31:ADDR_WIDTH], mem.addr[1:0]};

    assign accept = mem.req && ready_q && !flush;

    // On the accept edge the first lane comes straight from the request, so
    // the first store byte is on the RAM port in the cycle after acceptance.
    assign sel_mask  = (state_q == S_IDLE) ? mem.mask : rem_q;
    assign sel_base  = (state_q == S_IDLE) ? mem.addr[ADDR_WIDTH-1:2] : base_q;
    assign sel_wdata = (state_q == S_IDLE) ? mem.wdata : wdata_q;

    assign issue_store = ((state_q == S_IDLE && accept && mem.we) || state_q == S_WRITE)
                         && !none_left;

    data_mem_ctrl_mask_next_lane u_next_lane (
        .mask (sel_mask),
        .lane (lane),
        .none (none_left)
    );

    always_comb begin
        state_n    = state_q;
        ready_n    = ready_q;
        rvalid_n   = 1'b0;
        rdata_n    = rdata_q;
        ram_addr_n = ram_addr;
        ram_dout_n = ram_dout;
        ram_wr_n   = 1'b0;
        base_n     = base_q;
        wdata_n    = wdata_q;
        rem_n      = rem_q;
        cnt_n      = cnt_q;
        rbytes_n   = rbytes_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ready_n = 1'b0;
                    base_n  = mem.addr[ADDR_WIDTH-1:2];
                    wdata_n = mem.wdata;
                    if (mem.we) begin
                        state_n = S_WRITE;
                        rem_n   = '0;
                    end else begin
                        state_n    = S_READ;
                        cnt_n      = '0;
                        ram_addr_n = {mem.addr[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
            end

            S_READ: begin
                if (flush) begin
                    state_n = S_IDLE;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + 3'd1;
                    if (cnt_q < 3'd3) begin
                        ram_addr_n = {base_q, cnt_q[1:0] + 2'd1};
                    end
                    // RAM data trails the address by one cycle, hence the k+1 offset.
                    case (cnt_q)
                        3'd1: rbytes_n[7:0]   = ram_din;
                        3'd2: rbytes_n[15:8]  = ram_din;
                        3'd3: rbytes_n[23:16] = ram_din;
                        3'd4: begin
                            rdata_n  = {ram_din, rbytes_q};
                            rvalid_n = 1'b1;
                            ready_n  = 1'b1;
                            state_n  = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end

            S_WRITE: begin
                if (none_left) begin
                    state_n = S_IDLE;
                    ready_n = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
        endcase

        if (issue_store) begin
            ram_wr_n   = 1'b1;
            ram_addr_n = {sel_base, lane};
            ram_dout_n = lane_byte(sel_wdata, lane);
            rem_n      = sel_mask & ~(4'b0001 << lane);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            ram_addr <= '0;
            ram_dout <= '0;
            ram_wr   <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            rbytes_q <= '0;
        end else begin
            state_q  <= state_n;
            ready_q  <= ready_n;
            rvalid_q <= rvalid_n;
            rdata_q  <= rdata_n;
            ram_addr <= ram_addr_n;
            ram_dout <= ram_dout_n;
            ram_wr   <= ram_wr_n;
            base_q   <= base_n;
            wdata_q  <= wdata_n;
            rem_q    <= rem_n;
            cnt_q    <= cnt_n;
            rbytes_q <= rbytes_n;
        end
    end

    assign mem.ready  = ready_q;
    assign mem.rvalid = rvalid_q;
    assign mem.rdata  = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte RAM model, directed vector table, flush/reset
// sequences and randomized loads/stores against a byte-array reference.
module tb_data_mem_ctrl;

    localparam int unsigned AW        = 17;
    localparam int unsigned RAM_BYTES = 1 << AW;
    localparam int unsigned NV        = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout;
    logic          ram_wr;
    logic [7:0]    ram_din;

    data_mem_ctrl_if mem_bus ();

    data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .mem      (mem_bus),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .ram_wr   (ram_wr),
        .ram_din  (ram_din)
    );

    always #5 clk = ~clk;

    logic [7:0]    ram       [RAM_BYTES];
    logic [7:0]    model_mem [RAM_BYTES];
    logic [AW+7:0] wlog[$];
    int            rv_pulses = 0;

    // Byte RAM: synchronous write, registered read (one cycle latency).
    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_addr] <= ram_dout;
            wlog.push_back({ram_addr, ram_dout});
        end
        ram_din <= ram[ram_addr];
        if (mem_bus.rvalid) rv_pulses++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] word_base(input logic [31:0] a);
        return {a[AW-1:2], 2'b00};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        logic [AW-1:0] b;
        b = word_base(a);
        return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},    32'(mem_bus.ready), 32'd1);
        check({tag, "_rvalid"},   32'(mem_bus.rvalid), 32'd0);
        check({tag, "_rdata"},    mem_bus.rdata, 32'd0);
        check({tag, "_ram_wr"},   32'(ram_wr), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_dout"}, 32'(ram_dout), 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!mem_bus.ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!mem_bus.ready) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, input bit fl, output int cyc);
        logic [AW-1:0] base;
        logic [AW-1:0] ea;
        logic [AW+7:0] got;
        int            n;
        wait_ready();
        base = word_base(addr);
        mem_bus.req   = 1'b1;
        mem_bus.we    = 1'b1;
        mem_bus.addr  = addr;
        mem_bus.wdata = wdata;
        mem_bus.mask  = mask;
        wlog.delete();
        @(posedge clk);
        #1;
        mem_bus.req = 1'b0;
        if (fl) flush = 1'b1;
        check("st_busy_after_accept", 32'(mem_bus.ready), 32'd0);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_bus.ready) break;
        end
        flush = 1'b0;
        n = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) begin
                ea = base + AW'(i);
                model_mem[ea] = wdata[8*i +: 8];
                got = (n < wlog.size()) ? wlog[n] : '1;
                check("st_write_seq", 32'(got), 32'({ea, wdata[8*i +: 8]}));
                n++;
            end
        end
        check("st_write_count", 32'(wlog.size()), 32'(n));
    endtask

    task automatic run_load(input logic [31:0] addr, output logic [31:0] data, output int cyc);
        logic [AW-1:0] base;
        int            rv0;
        wait_ready();
        base = word_base(addr);
        mem_bus.req  = 1'b1;
        mem_bus.we   = 1'b0;
        mem_bus.addr = addr;
        mem_bus.mask = 4'hF;
        wlog.delete();
        rv0 = rv_pulses;
        @(posedge clk);
        #1;
        mem_bus.req = 1'b0;
        check("ld_busy_after_accept", 32'(mem_bus.ready), 32'd0);
        cyc = 0;
        while (cyc < 20) begin
            if (cyc < 4) check("ld_ram_addr", 32'(ram_addr), 32'(base + AW'(cyc)));
            @(posedge clk);
            #1;
            cyc++;
            if (mem_bus.rvalid || mem_bus.ready) break;
        end
        data = mem_bus.rdata;
        check("ld_rvalid", 32'(mem_bus.rvalid), 32'd1);
        check("ld_ready_with_rvalid", 32'(mem_bus.ready), 32'd1);
        @(posedge clk);
        #1;
        check("ld_rvalid_cleared", 32'(mem_bus.rvalid), 32'd0);
        check("ld_rdata_held", mem_bus.rdata, data);
        check("ld_pulse_count", 32'(rv_pulses - rv0), 32'd1);
        check("ld_no_ram_write", 32'(wlog.size()), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          exp_cyc;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t          vecs [NV];
    int            cyc;
    int            rv0;
    logic [31:0]   data;
    logic [31:0]   last_rdata;
    logic [31:0]   ra, rw;
    logic [3:0]    rm;
    logic [AW-1:0] held_addr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        for (int unsigned i = 0; i < RAM_BYTES; i++) begin
            ram[i]       = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            ram[32'h100 + i]       = 8'h11 * 8'(i + 1);
            model_mem[32'h100 + i] = 8'h11 * 8'(i + 1);
            ram[32'h300 + i]       = 8'hA0 + 8'(i);
            model_mem[32'h300 + i] = 8'hA0 + 8'(i);
        end

        vecs[0]  = '{1'b0, 32'h0000_0102, 32'h0,         4'h0, 5, 32'h4433_2211};
        vecs[1]  = '{1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 4, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0201, 32'h0,         4'h0, 5, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 32'h0000_0302, 32'h00AB_0000, 4'h4, 1, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0300, 32'h0,         4'h0, 5, 32'hA3AB_A1A0};
        vecs[5]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h0, 1, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 5, 32'h4433_2211};
        vecs[7]  = '{1'b1, 32'h0000_0101, 32'h5500_0066, 4'h9, 2, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 5, 32'h5533_2266};
        vecs[9]  = '{1'b0, 32'hFFFE_0104, 32'h0,         4'h0, 5, 32'h5D5C_5F5E};
        vecs[10] = '{1'b1, 32'h0001_FFFD, 32'hC3C2_C1C0, 4'hA, 2, 32'h0};
        vecs[11] = '{1'b0, 32'h0001_FFFC, 32'h0,         4'h0, 5, 32'hC3A4_C1A6};

        mem_bus.req   = 1'b0;
        mem_bus.we    = 1'b0;
        mem_bus.addr  = '0;
        mem_bus.wdata = '0;
        mem_bus.mask  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int unsigned k = 0; k < NV; k++) begin
            if (vecs[k].we) begin
                run_store(vecs[k].addr, vecs[k].wdata, vecs[k].mask, 1'b0, cyc);
                check("vec_store_cycles", 32'(cyc), 32'(vecs[k].exp_cyc));
            end else begin
                run_load(vecs[k].addr, data, cyc);
                check("vec_load_cycles", 32'(cyc), 32'(vecs[k].exp_cyc));
                check("vec_load_data", data, vecs[k].exp_rdata);
                last_rdata = data;
            end
        end

        // Flush two edges into a load: abort, no response, rdata untouched.
        wait_ready();
        mem_bus.req  = 1'b1;
        mem_bus.we   = 1'b0;
        mem_bus.addr = 32'h0000_0104;
        rv0 = rv_pulses;
        @(posedge clk);
        #1;
        mem_bus.req = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_rd_ready", 32'(mem_bus.ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("flush_rd_no_rvalid", 32'(rv_pulses - rv0), 32'd0);
        check("flush_rd_rdata_kept", mem_bus.rdata, last_rdata);
        run_load(32'h0000_0104, data, cyc);
        check("after_flush_load", data, 32'h5D5C_5F5E);
        check("after_flush_cycles", 32'(cyc), 32'd5);

        // Flush held throughout a store: all bytes still land.
        run_store(32'h0000_0600, 32'h8765_4321, 4'hF, 1'b1, cyc);
        check("flush_wr_cycles", 32'(cyc), 32'd4);
        run_load(32'h0000_0603, data, cyc);
        check("flush_wr_readback", data, 32'h8765_4321);

        // Request coinciding with flush in IDLE is dropped.
        wait_ready();
        wlog.delete();
        held_addr     = ram_addr;
        flush         = 1'b1;
        mem_bus.req   = 1'b1;
        mem_bus.we    = 1'b1;
        mem_bus.addr  = 32'h0000_0700;
        mem_bus.wdata = 32'h1234_5678;
        mem_bus.mask  = 4'hF;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("flush_accept_ready", 32'(mem_bus.ready), 32'd1);
        end
        mem_bus.req = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        #1;
        check("flush_accept_no_wr", 32'(wlog.size()), 32'd0);
        check("flush_accept_addr_held", 32'(ram_addr), 32'(held_addr));

        // Reset two edges into a full-word store: only lanes 0 and 1 written.
        wait_ready();
        mem_bus.req   = 1'b1;
        mem_bus.we    = 1'b1;
        mem_bus.addr  = 32'h0000_0500;
        mem_bus.wdata = 32'h4433_2211;
        mem_bus.mask  = 4'hF;
        wlog.delete();
        @(posedge clk);
        #1;
        mem_bus.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_mid_wr");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_wr_count", 32'(wlog.size()), 32'd2);
        model_mem[32'h500] = 8'h11;
        model_mem[32'h501] = 8'h22;
        run_load(32'h0000_0500, data, cyc);
        check("rst_mid_wr_readback", data, 32'h5958_2211);

        // Randomized traffic against the byte-array reference.
        for (int unsigned t = 0; t < 40; t++) begin
            ra = {15'($urandom), 17'h00400 | 17'($urandom_range(0, 63))};
            rw = $urandom;
            rm = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                run_store(ra, rw, rm, 1'($urandom_range(0, 1)), cyc);
                check("rnd_store_cycles", 32'(cyc), (rm == 4'h0) ? 32'd1 : 32'($countones(rm)));
            end else begin
                run_load(ra, data, cyc);
                check("rnd_load_cycles", 32'(cyc), 32'd5);
                check("rnd_load_data", data, model_load(ra));
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
